// File: rtl/cmp_issuer.sv
// Compare-request issuer: accepts one request, drives it to an external combinational
// compare unit for one cycle, then holds the captured result until downstream takes it.
module cmp_issuer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [2:0]       in_a,
    input  logic [2:0]       in_b,
    output logic [4:0]       cmp_opcode,
    output logic [2:0]       cmp_r1,
    output logic [2:0]       cmp_r2,
    input  logic [2:0]       cmp_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_result,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       r_state;
    logic [4:0]       r_opcode;
    logic [2:0]       r_a;
    logic [2:0]       r_b;
    logic [2:0]       r_result;
    logic             r_illegal;
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic             w_legal;
    logic             w_issue;

    // Legal opcodes are the contiguous range LT (01011) .. NE (10000).
    assign w_legal = (in_opcode >= 5'b01011) && (in_opcode <= 5'b10000);
    assign w_issue = (r_state == ISSUE);

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == RESP);
    assign out_result  = r_result;
    assign out_illegal = r_illegal;
    assign issued_cnt  = r_issued_cnt;
    assign illegal_cnt = r_illegal_cnt;

    assign cmp_opcode = w_issue ? r_opcode : 5'd0;
    assign cmp_r1     = w_issue ? r_a      : 3'd0;
    assign cmp_r2     = w_issue ? r_b      : 3'd0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= IDLE;
            r_opcode      <= 5'd0;
            r_a           <= 3'd0;
            r_b           <= 3'd0;
            r_result      <= 3'd0;
            r_illegal     <= 1'b0;
            r_issued_cnt  <= '0;
            r_illegal_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opcode <= in_opcode;
                        r_a      <= in_a;
                        r_b      <= in_b;
                        if (w_legal) begin
                            r_state <= ISSUE;
                        end else begin
                            r_result      <= 3'd0;
                            r_illegal     <= 1'b1;
                            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
                            r_state       <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_result     <= cmp_rd;
                    r_illegal    <= 1'b0;
                    r_issued_cnt <= r_issued_cnt + CNT_W'(1);
                    r_state      <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_issuer.sv
// Directed bench for cmp_issuer with a behavioural compare unit on the cmp_* ports.
module tb_cmp_issuer;

    logic       Clk;
    logic       Rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_opcode;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic [4:0] cmp_opcode;
    logic [2:0] cmp_r1;
    logic [2:0] cmp_r2;
    logic [2:0] cmp_rd;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_result;
    logic       out_illegal;
    logic [7:0] issued_cnt;
    logic [7:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] T = 3'b101;
    localparam logic [2:0] F = 3'b010;

    cmp_issuer #(.CNT_W(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .cmp_opcode (cmp_opcode),
        .cmp_r1     (cmp_r1),
        .cmp_r2     (cmp_r2),
        .cmp_rd     (cmp_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_illegal(out_illegal),
        .issued_cnt (issued_cnt),
        .illegal_cnt(illegal_cnt)
    );

    // Compare unit: true -> 3'b101, false -> 3'b010, so neither matches the illegal result 0.
    always_comb begin
        cmp_rd = 3'd0;
        case (cmp_opcode)
            5'b01011: cmp_rd = (cmp_r1 <  cmp_r2) ? T : F;
            5'b01100: cmp_rd = (cmp_r1 >  cmp_r2) ? T : F;
            5'b01101: cmp_rd = (cmp_r1 == cmp_r2) ? T : F;
            5'b01110: cmp_rd = (cmp_r1 >= cmp_r2) ? T : F;
            5'b01111: cmp_rd = (cmp_r1 <= cmp_r2) ? T : F;
            5'b10000: cmp_rd = (cmp_r1 != cmp_r2) ? T : F;
            default:  cmp_rd = 3'd0;
        endcase
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        tick();
        in_valid = 1'b0;
    endtask

    logic [4:0] ops [6];
    logic [2:0] masks [6];
    logic [2:0] pa [3];
    logic [2:0] pb [3];
    logic [2:0] exp_r;
    int         prev;
    int         pulses;

    initial begin
        // mask bit0: a==b true, bit1: a<b true, bit2: a>b true
        ops[0] = 5'b01011; masks[0] = 3'b010;
        ops[1] = 5'b01100; masks[1] = 3'b100;
        ops[2] = 5'b01101; masks[2] = 3'b001;
        ops[3] = 5'b01110; masks[3] = 3'b101;
        ops[4] = 5'b01111; masks[4] = 3'b011;
        ops[5] = 5'b10000; masks[5] = 3'b110;
        pa[0] = 3'd3; pb[0] = 3'd3;
        pa[1] = 3'd1; pb[1] = 3'd6;
        pa[2] = 3'd6; pb[2] = 3'd1;

        Rst = 1'b1; in_valid = 1'b1; in_opcode = 5'b01011; in_a = 3'd1; in_b = 3'd2;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_cmp_opcode", cmp_opcode, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_illegal_cnt", illegal_cnt, 0);
        in_valid = 1'b0;
        Rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // LT 3,5
        send(5'b01011, 3'd3, 3'd5);
        chk("lt_cmp_opcode", cmp_opcode, 5'b01011);
        chk("lt_cmp_r1", cmp_r1, 3);
        chk("lt_cmp_r2", cmp_r2, 5);
        chk("lt_issue_valid", out_valid, 0);
        chk("lt_issue_ready", in_ready, 0);
        tick();
        chk("lt_out_valid", out_valid, 1);
        chk("lt_out_result", out_result, T);
        chk("lt_out_illegal", out_illegal, 0);
        chk("lt_issued", issued_cnt, 1);
        chk("lt_cmp_idle", cmp_opcode, 0);
        tick();
        chk("lt_back_idle", in_ready, 1);
        chk("lt_valid_drop", out_valid, 0);

        // Illegal 00111 2,2
        send(5'b00111, 3'd2, 3'd2);
        chk("ill_out_valid", out_valid, 1);
        chk("ill_out_result", out_result, 0);
        chk("ill_out_illegal", out_illegal, 1);
        chk("ill_cnt", illegal_cnt, 1);
        chk("ill_issued", issued_cnt, 1);
        chk("ill_cmp_opcode", cmp_opcode, 0);
        chk("ill_cmp_r1", cmp_r1, 0);
        tick();
        chk("ill_back_idle", in_ready, 1);

        // NE 2,6 with downstream stalled; a second request must be ignored
        out_ready = 1'b0;
        send(5'b10000, 3'd2, 3'd6);
        tick();
        in_valid = 1'b1; in_opcode = 5'b01011; in_a = 3'd7; in_b = 3'd0;
        for (int i = 0; i < 4; i++) begin
            chk("ne_hold_valid", out_valid, 1);
            chk("ne_hold_result", out_result, T);
            chk("ne_hold_illegal", out_illegal, 0);
            chk("ne_hold_ready", in_ready, 0);
            chk("ne_hold_cmp", cmp_opcode, 0);
            tick();
        end
        chk("ne_issued", issued_cnt, 2);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ne_release_valid", out_valid, 0);
        chk("ne_release_ready", in_ready, 1);
        chk("ne_release_issued", issued_cnt, 2);

        // Reset while in ISSUE abandons the request
        send(5'b01110, 3'd4, 3'd4);
        chk("gte_cmp_opcode", cmp_opcode, 5'b01110);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_issued", issued_cnt, 0);
        chk("abort_illegal_cnt", illegal_cnt, 0);
        tick();
        chk("abort_valid2", out_valid, 0);

        // Every legal opcode against equal / less / greater operands
        for (int o = 0; o < 6; o++) begin
            for (int p = 0; p < 3; p++) begin
                exp_r = masks[o][p] ? T : F;
                send(ops[o], pa[p], pb[p]);
                chk("tab_cmp_opcode", cmp_opcode, ops[o]);
                tick();
                chk("tab_result", out_result, exp_r);
                chk("tab_illegal", out_illegal, 0);
                tick();
            end
        end
        chk("tab_issued", issued_cnt, 18);

        // 256 back-to-back EQ: spacing of 3 cycles and counter wrap
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        in_valid = 1'b1; in_opcode = 5'b01101; in_a = 3'd5; in_b = 3'd5;
        prev = -1;
        pulses = 0;
        for (int c = 0; c < 1000 && pulses < 256; c++) begin
            tick();
            if (out_valid) begin
                if (prev >= 0) chk("b2b_spacing", c - prev, 3);
                prev = c;
                pulses++;
            end
        end
        chk("b2b_pulses", pulses, 256);
        chk("b2b_wrap", issued_cnt, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_issuer.md
CMP_ISSUER -- requirements
Module: cmp_issuer

Interface
REQ-001 Parameter CNT_W, default 8: width of the issued-operation and illegal-operation counters.
REQ-002 Port Clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port Rst  input  1: synchronous, active-high reset, sampled on rising edge of Clk.
REQ-004 Port in_valid  input  1: upstream holds a compare request.
REQ-005 Port in_ready  output  1: block accepts a request this cycle.
REQ-006 Port in_opcode  input  5: compare opcode.
REQ-007 Port in_a  input  3: first operand value.
REQ-008 Port in_b  input  3: second operand value.
REQ-009 Port cmp_opcode  output  5: opcode driven to the compare unit.
REQ-010 Port cmp_r1  output  3: first operand driven to the compare unit.
REQ-011 Port cmp_r2  output  3: second operand driven to the compare unit.
REQ-012 Port cmp_rd  input  3: combinational result returned by the compare unit.
REQ-013 Port out_valid  output  1: result available.
REQ-014 Port out_ready  input  1: downstream accepts result.
REQ-015 Port out_result  output  3: captured compare result.
REQ-016 Port out_illegal  output  1: request carried an unsupported opcode.
REQ-017 Port issued_cnt  output  CNT_W: count of requests issued to the compare unit.
REQ-018 Port illegal_cnt  output  CNT_W: count of requests rejected as illegal.

Function
REQ-019 Legal opcodes SHALL be 01011 LT, 01100 GT, 01101 EQ, 01110 GTE, 01111 LTE, 10000 NE; all others SHALL be illegal.
REQ-020 FSM states SHALL be IDLE, ISSUE, RESP; only IDLE SHALL assert in_ready.
REQ-021 Handshake in_valid&in_ready at edge N SHALL register in_opcode/in_a/in_b; legal -> ISSUE, illegal -> RESP.
REQ-022 In ISSUE, cmp_opcode/cmp_r1/cmp_r2 SHALL be driven from the registered request, held stable the entire cycle.
REQ-023 At edge N+1 from ISSUE, cmp_rd SHALL be captured into out_result, out_illegal cleared, state -> RESP, issued_cnt incremented.
REQ-024 Illegal path: at edge N, out_result SHALL be set to 3'd0, out_illegal to 1, illegal_cnt incremented; compare ports SHALL NOT be driven with the request.
REQ-025 Outside ISSUE, cmp_opcode, cmp_r1, cmp_r2 SHALL be 0.
REQ-026 out_valid SHALL be 1 exactly in RESP; out_result and out_illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 out_valid&out_ready at an edge SHALL return state to IDLE; next request is acceptable no earlier than the following cycle (max one request per 3 cycles legal, per 2 cycles illegal).
REQ-028 Latency: legal request accepted at edge N SHALL show out_valid=1 after edge N+1; illegal request SHALL show out_valid=1 after edge N.
REQ-029 Counters SHALL wrap modulo 2^CNT_W with no saturation or flag.
REQ-030 in_valid while not in IDLE SHALL be ignored; request remains pending upstream.

Reset
REQ-031 Rst=1 at an edge SHALL force IDLE, out_valid=0, out_result=0, out_illegal=0, cmp_* =0, issued_cnt=0, illegal_cnt=0, overriding any handshake at that edge.
REQ-032 Rst during ISSUE or RESP SHALL abandon the request with no out_valid pulse and no counter increment.
REQ-033 in_ready SHALL be 1 in the first cycle after Rst deasserts.

Verification
REQ-034 LT a=3 b=5, out_ready=1 -> cmp_opcode=01011, cmp_r1=3, cmp_r2=5 in ISSUE; out_valid one cycle later with out_result=compare-unit value, issued_cnt=1.
REQ-035 Opcode 00111 a=2 b=2 -> out_valid after 1 edge, out_result=0, out_illegal=1, illegal_cnt=1, cmp_opcode stays 0.
REQ-036 NE a=2 b=6 with out_ready=0 for 4 cycles -> out_valid and out_result held 4 cycles, in_ready=0, second in_valid ignored; released when out_ready=1.
REQ-037 Rst asserted in ISSUE of GTE a=4 b=4 -> next cycle IDLE, out_valid never 1, issued_cnt=0.
REQ-038 256 back-to-back EQ requests with CNT_W=8 -> issued_cnt wraps to 0, each out_valid spaced 3 cycles apart.
REQ-039 All six legal opcodes with operand pairs equal, less, greater -> out_result matches compare-unit truth for each, out_illegal=0.
